// File: rtl/frame_bram_arbiter.sv
// rtl/frame_bram_arbiter.sv - still-frame BRAM port owner and capture sequencer
//
// Owns the single BRAM port and shares it between the capture writer (VGA pixel
// stream), the display reader and the image-processing reader.
//
// Ports:
//   clock_i, reset_n_i          clock, synchronous active-low reset
//   capture_req_i, release_i    capture arm / discard pulses
//   hcount_i, vcount_i          raster position of pixel_in_i
//   pixel_in_i                  RGB332 pixel being scanned out
//   disp_rd_i, disp_addr_i      display read request (highest read priority)
//   disp_valid_o, disp_data_o   display read return
//   proc_req_i, proc_addr_i     processor read request, held until proc_gnt_o
//   proc_gnt_o                  processor address accepted this cycle
//   proc_valid_o, proc_data_o   processor read return
//   bram_addr_o, bram_din_o,
//   bram_we_o, bram_dout_i      BRAM port
//   state_o                     IDLE=0 ARMED=1 WRITING=2 FROZEN=3
//   frame_ready_o               high while a frozen frame is held
//   capture_done_o              one-cycle pulse on entering FROZEN
module frame_bram_arbiter #(
   parameter int H_ACTIVE     = 640,
   parameter int V_ACTIVE     = 400,
   parameter int FRAME_SIZE   = H_ACTIVE * V_ACTIVE,
   parameter int ADDR_W       = 18,
   parameter int READ_LATENCY = 2
) (
   input  logic              clock_i,
   input  logic              reset_n_i,
   input  logic              capture_req_i,
   input  logic              release_i,
   input  logic [10:0]       hcount_i,
   input  logic [9:0]        vcount_i,
   input  logic [7:0]        pixel_in_i,
   input  logic              disp_rd_i,
   input  logic [ADDR_W-1:0] disp_addr_i,
   output logic              disp_valid_o,
   output logic [7:0]        disp_data_o,
   input  logic              proc_req_i,
   input  logic [ADDR_W-1:0] proc_addr_i,
   output logic              proc_gnt_o,
   output logic              proc_valid_o,
   output logic [7:0]        proc_data_o,
   output logic [ADDR_W-1:0] bram_addr_o,
   output logic [7:0]        bram_din_o,
   output logic              bram_we_o,
   input  logic [7:0]        bram_dout_i,
   output logic [1:0]        state_o,
   output logic              frame_ready_o,
   output logic              capture_done_o
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARMED   = 2'd1,
      WRITING = 2'd2,
      FROZEN  = 2'd3
   } state_t;

   localparam logic [10:0]       H_LIM     = 11'(H_ACTIVE);
   localparam logic [9:0]        V_LIM     = 10'(V_ACTIVE);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_SIZE - 1);

   state_t                  state_q, state_d;
   logic [ADDR_W-1:0]       wr_cnt_q, wr_cnt_d;
   logic [ADDR_W-1:0]       addr_hold_q;
   logic                    frame_ready_q;
   logic                    capture_done_q, capture_done_d;
   logic [READ_LATENCY-1:0] disp_sr_q, proc_sr_q;
   logic                    in_display;
   logic                    disp_issue, proc_issue;

   assign in_display = (hcount_i < H_LIM) && (vcount_i < V_LIM);
   assign disp_issue = (state_q == FROZEN) && disp_rd_i;
   assign proc_issue = (state_q == FROZEN) && proc_req_i && !disp_rd_i;

   always_comb begin
      state_d        = state_q;
      wr_cnt_d       = wr_cnt_q;
      capture_done_d = 1'b0;
      bram_we_o      = 1'b0;
      bram_addr_o    = addr_hold_q;
      bram_din_o     = '0;

      // release wins over any same-cycle capture_req
      if (release_i && (state_q != IDLE)) begin
         state_d  = IDLE;
         wr_cnt_d = '0;
      end else begin
         case (state_q)
            IDLE:    if (capture_req_i) state_d = ARMED;
            // starting in vertical blanking guarantees the first write is pixel (0,0)
            ARMED: begin
               if (vcount_i == V_LIM) begin
                  state_d  = WRITING;
                  wr_cnt_d = '0;
               end
            end
            WRITING: begin
               if (in_display) begin
                  if (wr_cnt_q == LAST_ADDR) begin
                     state_d        = FROZEN;
                     capture_done_d = 1'b1;
                  end else begin
                     wr_cnt_d = wr_cnt_q + ADDR_W'(1);
                  end
               end
            end
            FROZEN:  if (capture_req_i) state_d = ARMED;
            default: state_d = IDLE;
         endcase
      end

      // the port follows the current state; a release only takes effect at the edge
      case (state_q)
         WRITING: begin
            bram_we_o   = in_display;
            bram_addr_o = wr_cnt_q;
            bram_din_o  = pixel_in_i;
         end
         FROZEN: begin
            if (disp_rd_i)       bram_addr_o = disp_addr_i;
            else if (proc_req_i) bram_addr_o = proc_addr_i;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock_i) begin
      if (!reset_n_i) begin
         state_q        <= IDLE;
         wr_cnt_q       <= '0;
         addr_hold_q    <= '0;
         frame_ready_q  <= 1'b0;
         capture_done_q <= 1'b0;
         disp_sr_q      <= '0;
         proc_sr_q      <= '0;
      end else begin
         state_q        <= state_d;
         wr_cnt_q       <= wr_cnt_d;
         addr_hold_q    <= bram_addr_o;
         frame_ready_q  <= (state_d == FROZEN);
         capture_done_q <= capture_done_d;
         // in-flight reads keep draining across state changes
         disp_sr_q      <= (disp_sr_q << 1) | READ_LATENCY'(disp_issue);
         proc_sr_q      <= (proc_sr_q << 1) | READ_LATENCY'(proc_issue);
      end
   end

   assign proc_gnt_o     = proc_issue;
   assign disp_valid_o   = disp_sr_q[READ_LATENCY-1];
   assign proc_valid_o   = proc_sr_q[READ_LATENCY-1];
   assign disp_data_o    = disp_valid_o ? bram_dout_i : 8'd0;
   assign proc_data_o    = proc_valid_o ? bram_dout_i : 8'd0;
   assign state_o        = state_q;
   assign frame_ready_o  = frame_ready_q;
   assign capture_done_o = capture_done_q;

endmodule

// File: tb/tb_frame_bram_arbiter.sv
// tb/tb_frame_bram_arbiter.sv - self-checking bench for frame_bram_arbiter
module tb_frame_bram_arbiter;

   localparam int H_ACT = 8;
   localparam int V_ACT = 4;
   localparam int FS    = 32;
   localparam int AW    = 18;
   localparam int RL    = 2;
   localparam int H_TOT = 10;
   localparam int V_TOT = 6;

   logic          clk = 1'b0;
   logic          reset_n, capture_req, rel, disp_rd, proc_req;
   logic [10:0]   hcount;
   logic [9:0]    vcount;
   logic [7:0]    pixel_in;
   logic [AW-1:0] disp_addr, proc_addr, bram_addr;
   logic          disp_valid, proc_gnt, proc_valid, bram_we, frame_ready, capture_done;
   logic [7:0]    disp_data, proc_data, bram_din, bram_dout;
   logic [1:0]    state;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   frame_bram_arbiter #(
      .H_ACTIVE(H_ACT), .V_ACTIVE(V_ACT), .ADDR_W(AW), .READ_LATENCY(RL)
   ) dut (
      .clock_i(clk), .reset_n_i(reset_n), .capture_req_i(capture_req), .release_i(rel),
      .hcount_i(hcount), .vcount_i(vcount), .pixel_in_i(pixel_in),
      .disp_rd_i(disp_rd), .disp_addr_i(disp_addr), .disp_valid_o(disp_valid), .disp_data_o(disp_data),
      .proc_req_i(proc_req), .proc_addr_i(proc_addr), .proc_gnt_o(proc_gnt),
      .proc_valid_o(proc_valid), .proc_data_o(proc_data),
      .bram_addr_o(bram_addr), .bram_din_o(bram_din), .bram_we_o(bram_we), .bram_dout_i(bram_dout),
      .state_o(state), .frame_ready_o(frame_ready), .capture_done_o(capture_done)
   );

   task automatic chk(input string name, input longint act, input longint exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // BRAM with two-cycle read latency; also logs what the DUT writes
   logic [7:0] mem [0:FS-1];
   logic [7:0] rd1;
   int wr_count = 0;
   int seq_err  = 0;
   always @(posedge clk) begin
      rd1       <= mem[bram_addr[4:0]];
      bram_dout <= rd1;
      if (bram_we) begin
         if (int'(bram_addr) != wr_count) seq_err++;
         mem[bram_addr[4:0]] <= bram_din;
         wr_count++;
      end
   end

   // Reference model: frame state by rule, reads as a queue of timed returns
   typedef struct {
      longint     due;
      bit         is_proc;
      logic [7:0] data;
   } rd_t;
   rd_t        rq[$];
   int         m_state = 0, m_cnt = 0, m_ready = 0, m_done = 0, m_nxt = 0;
   bit         m_live = 1'b0;
   longint     cyc = 0;
   logic [7:0] m_mem [0:FS-1];

   function automatic bit in_disp();
      return (int'(hcount) < H_ACT) && (int'(vcount) < V_ACT);
   endfunction

   always @(posedge clk) begin
      while (rq.size() > 0 && rq[0].due <= cyc) void'(rq.pop_front());
      if (!reset_n) begin
         m_state = 0; m_cnt = 0; m_ready = 0; m_done = 0;
         rq.delete();
         m_live = 1'b1;
      end else if (m_live) begin
         if (m_state == 3 && disp_rd)
            rq.push_back('{cyc + RL, 1'b0, m_mem[disp_addr[4:0]]});
         else if (m_state == 3 && proc_req)
            rq.push_back('{cyc + RL, 1'b1, m_mem[proc_addr[4:0]]});
         m_nxt  = m_state;
         m_done = 0;
         if (rel && m_state != 0) begin
            m_nxt = 0; m_cnt = 0;
         end else if (m_state == 0 || m_state == 3) begin
            if (capture_req) m_nxt = 1;
         end else if (m_state == 1) begin
            if (int'(vcount) == V_ACT) begin m_nxt = 2; m_cnt = 0; end
         end else if (in_disp()) begin
            m_mem[m_cnt] = pixel_in;
            if (m_cnt == FS - 1) begin m_nxt = 3; m_done = 1; end
            else m_cnt++;
         end
         m_state = m_nxt;
         m_ready = (m_nxt == 3) ? 1 : 0;
      end
      cyc++;
   end

   bit         e_we, e_gnt, e_dv, e_pv;
   logic [7:0] e_dd, e_pd;
   int         done_pulses = 0, valid_seen = 0, ready_seen = 0;

   always @(negedge clk) begin
      if (capture_done) done_pulses++;
      if (disp_valid || proc_valid) valid_seen++;
      if (frame_ready) ready_seen++;
      if (m_live && reset_n) begin
         e_we  = (m_state == 2) && in_disp();
         e_gnt = (m_state == 3) && proc_req && !disp_rd;
         e_dv = 0; e_pv = 0; e_dd = 0; e_pd = 0;
         foreach (rq[i]) begin
            if (rq[i].due == cyc) begin
               if (rq[i].is_proc) begin e_pv = 1; e_pd = rq[i].data; end
               else begin e_dv = 1; e_dd = rq[i].data; end
            end
         end
         chk("state", state, m_state);
         chk("frame_ready", frame_ready, m_ready);
         chk("capture_done", capture_done, m_done);
         chk("bram_we", bram_we, e_we);
         chk("proc_gnt", proc_gnt, e_gnt);
         chk("disp_valid", disp_valid, e_dv);
         chk("disp_data", disp_data, e_dd);
         chk("proc_valid", proc_valid, e_pv);
         chk("proc_data", proc_data, e_pd);
         if (e_we) begin
            chk("wr_addr", bram_addr, m_cnt);
            chk("wr_din", bram_din, pixel_in);
         end else if (m_state == 3 && disp_rd) begin
            chk("rd_addr_disp", bram_addr, disp_addr);
         end else if (e_gnt) begin
            chk("rd_addr_proc", bram_addr, proc_addr);
         end
      end
   end

   // advance one clock; raster moves just after the edge
   task automatic tick();
      @(posedge clk);
      #1;
      if (int'(hcount) == H_TOT - 1) begin
         hcount = 11'd0;
         vcount = (int'(vcount) == V_TOT - 1) ? 10'd0 : vcount + 10'd1;
      end else begin
         hcount = hcount + 11'd1;
      end
      pixel_in = 8'(int'(vcount) * 8 + int'(hcount));
   endtask

   task automatic pulse_capture();
      capture_req = 1'b1;
      tick();
      capture_req = 1'b0;
   endtask

   task automatic wait_ready(input string name);
      for (int i = 0; i < 300; i++) begin
         #1;
         if (frame_ready) break;
         tick();
      end
      chk({name, "_ready_in_time"}, frame_ready, 1);
   endtask

   task automatic wait_write(input int addr, input string name);
      bit found = 1'b0;
      for (int i = 0; i < 300; i++) begin
         #1;
         if (bram_we && int'(bram_addr) == addr) begin found = 1'b1; break; end
         tick();
      end
      chk({name, "_write_found"}, found, 1);
   endtask

   task automatic check_frame(input string name);
      int bad = 0;
      for (int a = 0; a < FS; a++) if (mem[a] !== 8'(a)) bad++;
      chk({name, "_frame_bad_words"}, bad, 0);
   endtask

   initial begin
      reset_n = 1'b0; capture_req = 1'b0; rel = 1'b0; disp_rd = 1'b0; proc_req = 1'b0;
      disp_addr = '0; proc_addr = '0; hcount = '0; vcount = '0; pixel_in = '0;
      for (int a = 0; a < FS; a++) mem[a] = 8'hEE;
      tick();
      tick();
      reset_n = 1'b1;
      #1;
      chk("rst_state", state, 0);
      chk("rst_frame_ready", frame_ready, 0);
      chk("rst_capture_done", capture_done, 0);
      chk("rst_bram_we", bram_we, 0);
      chk("rst_bram_addr", bram_addr, 0);
      chk("rst_valids", {disp_valid, proc_valid, proc_gnt}, 0);

      // capture: armed on line 1, first write waits for the next frame
      for (int i = 0; i < 100 && int'(vcount) != 1; i++) tick();
      wr_count = 0; seq_err = 0; done_pulses = 0;
      pulse_capture();
      #1;
      chk("cap1_armed", state, 1);
      wait_ready("cap1");
      chk("cap1_done_now", capture_done, 1);
      tick();
      #1;
      chk("cap1_writes", wr_count, 32);
      chk("cap1_seq_err", seq_err, 0);
      chk("cap1_done_pulses", done_pulses, 1);
      chk("cap1_state", state, 3);
      check_frame("cap1");

      // read priority
      disp_rd = 1'b1; disp_addr = 18'd5; proc_req = 1'b1; proc_addr = 18'd9;
      #1;
      chk("prio_gnt_blocked", proc_gnt, 0);
      tick();
      disp_rd = 1'b0;
      #1;
      chk("prio_gnt_granted", proc_gnt, 1);
      tick();
      proc_req = 1'b0;
      #1;
      chk("prio_disp_valid", disp_valid, 1);
      chk("prio_disp_data", disp_data, 5);
      tick();
      #1;
      chk("prio_proc_valid", proc_valid, 1);
      chk("prio_proc_data", proc_data, 9);
      chk("prio_disp_idle", disp_valid, 0);

      // back-to-back mixed reads
      for (int i = 0; i < 12; i++) begin
         tick();
         disp_rd = (i % 3 == 0); disp_addr = AW'(i * 2);
         proc_req = 1'b1; proc_addr = AW'(31 - i);
      end
      tick();
      disp_rd = 1'b0; proc_req = 1'b0;
      tick();
      tick();

      // recapture: reads held high are ignored until the frame is back
      pulse_capture();
      #1;
      chk("recap_armed", state, 1);
      chk("recap_ready_low", frame_ready, 0);
      disp_rd = 1'b1; disp_addr = 18'd3; proc_req = 1'b1; proc_addr = 18'd4;
      wr_count = 0; done_pulses = 0; valid_seen = 0;
      wait_ready("recap");
      chk("recap_no_reads", valid_seen, 0);
      chk("recap_done_now", capture_done, 1);
      tick();
      disp_rd = 1'b0; proc_req = 1'b0;
      chk("recap_writes", wr_count, 32);
      chk("recap_done_pulses", done_pulses, 1);
      tick();
      tick();
      tick();

      // simultaneous capture_req and release after a granted proc read
      proc_req = 1'b1; proc_addr = 18'd7;
      #1;
      chk("sim_gnt", proc_gnt, 1);
      tick();
      proc_req = 1'b0; capture_req = 1'b1; rel = 1'b1;
      tick();
      capture_req = 1'b0; rel = 1'b0;
      #1;
      chk("sim_state", state, 0);
      chk("sim_proc_valid", proc_valid, 1);
      chk("sim_proc_data", proc_data, 7);

      // abort at write address 17
      tick();
      pulse_capture();
      wait_write(17, "abort");
      rel = 1'b1;
      tick();
      rel = 1'b0;
      #1;
      chk("abort_we", bram_we, 0);
      chk("abort_state", state, 0);
      ready_seen = 0; valid_seen = 0;
      for (int i = 0; i < 80; i++) begin
         disp_rd = (i < 4); disp_addr = AW'(i);
         tick();
      end
      disp_rd = 1'b0;
      chk("abort_never_ready", ready_seen, 0);
      chk("abort_no_disp_valid", valid_seen, 0);

      // reset at write address 20, then restart from 0
      pulse_capture();
      wait_write(20, "rst_mid");
      reset_n = 1'b0;
      tick();
      reset_n = 1'b1;
      #1;
      chk("rstmid_state", state, 0);
      chk("rstmid_we", bram_we, 0);
      chk("rstmid_addr", bram_addr, 0);
      chk("rstmid_ready", frame_ready, 0);
      chk("rstmid_valids", {disp_valid, proc_valid, proc_gnt, capture_done}, 0);
      tick();
      wr_count = 0; seq_err = 0;
      pulse_capture();
      for (int i = 0; i < 300 && !bram_we; i++) begin tick(); #1; end
      chk("restart_first_addr", bram_addr, 0);
      wait_ready("restart");
      tick();
      chk("restart_writes", wr_count, 32);
      chk("restart_seq_err", seq_err, 0);
      check_frame("restart");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
      $fatal(1);
   end

endmodule
